// File: rtl/i2c_bus_cond_detect_pkg.sv
// Shared constants and types for the I2C bus front end.
// Used by i2c_sync_filter, by i2c_bus_cond_detect and by downstream FSMs.
package i2c_pkg;

  // Level of an undriven, pulled-up I2C line.
  localparam logic I2C_IDLE_LEVEL = 1'b1;

  // Default synchroniser depth and glitch-filter length.
  localparam int I2C_DEF_SYNC_STAGES = 2;
  localparam int I2C_DEF_FILT_LEN    = 3;

  // Bus condition seen on the filtered lines in one cycle.
  typedef enum logic [1:0] {
    COND_NONE,
    COND_START,
    COND_STOP
  } i2c_cond_t;

endpackage

// File: rtl/i2c_bus_cond_detect_sync_filter.sv
// i2c_sync_filter: synchronises one raw I2C pin into clk and removes glitches.
// The filtered level follows the synchronised level only after the two have
// disagreed for FILT_LEN consecutive cycles.
module i2c_sync_filter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = I2C_DEF_SYNC_STAGES,
  parameter int FILT_LEN    = I2C_DEF_FILT_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic d_f
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);

  // Reject illegal configurations while the design is being elaborated.
  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("i2c_sync_filter: SYNC_STAGES must be in 2..4");
    end
    if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt
      $error("i2c_sync_filter: FILT_LEN must be in 1..15");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   d_f_reg;
  logic                   synced;

  assign synced = sync_reg[SYNC_STAGES-1];
  assign d_f    = d_f_reg;

  // Plain flop chain: the pin is shifted in with nothing between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {SYNC_STAGES{I2C_IDLE_LEVEL}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d_in};
    end
  end

  // Count disagreeing cycles; adopt the new level on the FILT_LEN-th one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      d_f_reg <= I2C_IDLE_LEVEL;
    end else if (synced == d_f_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_W'(FILT_LEN - 1)) begin
      cnt_reg <= '0;
      d_f_reg <= synced;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_bus_cond_detect.sv
// i2c_bus_cond_detect: I2C subordinate front end. Produces filtered SCL/SDA,
// SCL edge strobes, START / repeated START / STOP pulses and bus_busy.
// Optional macro I2C_BUS_TIMEOUT_EN adds an SCL-low timeout that drops
// bus_busy; without it bus_timeout is tied low.
module i2c_bus_cond_detect
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES    = I2C_DEF_SYNC_STAGES,
  parameter int FILT_LEN       = I2C_DEF_FILT_LEN,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic rstart,
  output logic stop,
  output logic bus_busy,
  output logic bus_timeout
);

  localparam int LINE_SCL = 0;
  localparam int LINE_SDA = 1;

  // The timeout length must be meaningful even when the timeout is not built.
  generate
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("i2c_bus_cond_detect: TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  logic [1:0] pin_raw;
  logic [1:0] line_f;

  assign pin_raw = {sda_in, scl_in};

  // One synchroniser + glitch filter per line.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      i2c_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
      ) u_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (pin_raw[gi]),
        .d_f   (line_f[gi])
      );
    end
  endgenerate

  assign scl_f = line_f[LINE_SCL];
  assign sda_f = line_f[LINE_SDA];

  logic      prev_scl_reg;
  logic      prev_sda_reg;
  logic      scl_rise_reg;
  logic      scl_fall_reg;
  logic      start_reg;
  logic      rstart_reg;
  logic      stop_reg;
  logic      busy_reg;
  logic      timeout_pulse;
  i2c_cond_t cond;

  // Previous filtered levels, idle-high so reset release looks like no change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_scl_reg <= I2C_IDLE_LEVEL;
      prev_sda_reg <= I2C_IDLE_LEVEL;
    end else begin
      prev_scl_reg <= scl_f;
      prev_sda_reg <= sda_f;
    end
  end

  // SDA may only flag a condition if SCL was high both before and now,
  // which also suppresses conditions when both lines move together.
  always_comb begin
    cond = COND_NONE;
    if (prev_scl_reg && scl_f) begin
      if (prev_sda_reg && !sda_f) begin
        cond = COND_START;
      end else if (!prev_sda_reg && sda_f) begin
        cond = COND_STOP;
      end
    end
  end

  // Registered one-cycle strobes for SCL edges and bus conditions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_rise_reg <= 1'b0;
      scl_fall_reg <= 1'b0;
      start_reg    <= 1'b0;
      rstart_reg   <= 1'b0;
      stop_reg     <= 1'b0;
    end else begin
      scl_rise_reg <= !prev_scl_reg && scl_f;
      scl_fall_reg <= prev_scl_reg && !scl_f;
      start_reg    <= (cond == COND_START);
      rstart_reg   <= (cond == COND_START) && busy_reg;
      stop_reg     <= (cond == COND_STOP);
    end
  end

  // Busy follows the start/stop pulses; a START beats a simultaneous timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= 1'b0;
    end else if (start_reg) begin
      busy_reg <= 1'b1;
    end else if (stop_reg || timeout_pulse) begin
      busy_reg <= 1'b0;
    end
  end

`ifdef I2C_BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] timeout_cnt_reg;
  logic            timeout_reg;

  // Count busy cycles with SCL held low; pulse once the limit is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt_reg <= '0;
      timeout_reg     <= 1'b0;
    end else if (!busy_reg || scl_f) begin
      timeout_cnt_reg <= '0;
      timeout_reg     <= 1'b0;
    end else if (timeout_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
      timeout_cnt_reg <= '0;
      timeout_reg     <= 1'b1;
    end else begin
      timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
      timeout_reg     <= 1'b0;
    end
  end

  assign timeout_pulse = timeout_reg;
`else
  assign timeout_pulse = 1'b0;
`endif

  assign scl_rise    = scl_rise_reg;
  assign scl_fall    = scl_fall_reg;
  assign start       = start_reg;
  assign rstart      = rstart_reg;
  assign stop        = stop_reg;
  assign bus_busy    = busy_reg;
  assign bus_timeout = timeout_pulse;

endmodule

// File: tb/tb_i2c_bus_cond_detect.sv
// Self-checking bench for i2c_bus_cond_detect with a pulse scoreboard.
// Covers the I2C_BUS_TIMEOUT_EN build and the default build.
module tb_i2c_bus_cond_detect;

  localparam int SYNC = 2;
  localparam int FILT = 3;
  localparam int TO   = 20;
  localparam int LAT  = SYNC + FILT + 1;

  // Pulse vector layout: {start, rstart, stop, bus_timeout}
  localparam logic [3:0] V_START  = 4'b1000;
  localparam logic [3:0] V_RSTART = 4'b1100;
  localparam logic [3:0] V_STOP   = 4'b0010;
  localparam logic [3:0] V_TO     = 4'b0001;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic scl_in = 1'b0;
  logic sda_in = 1'b0;
  logic scl_f, sda_f, scl_rise, scl_fall, start, rstart, stop, bus_busy, bus_timeout;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t ent;
  logic [3:0] mon_vec;
  int cyc      = 0;
  int total    = 0;
  int bad      = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int c0, c1, r0, f0;

  i2c_bus_cond_detect #(
    .SYNC_STAGES    (SYNC),
    .FILT_LEN       (FILT),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl_in      (scl_in),
    .sda_in      (sda_in),
    .scl_f       (scl_f),
    .sda_f       (sda_f),
    .scl_rise    (scl_rise),
    .scl_fall    (scl_fall),
    .start       (start),
    .rstart      (rstart),
    .stop        (stop),
    .bus_busy    (bus_busy),
    .bus_timeout (bus_timeout)
  );

  always #5 clk = ~clk;

  // Cycle n is the interval after the n-th rising edge.
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input string tag, input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pins(input logic s, input logic d);
    scl_in = s;
    sda_in = d;
  endtask

  // Scoreboard: every condition pulse must match the head of the queue in cycle and kind.
  always @(negedge clk) begin
    mon_vec = {start, rstart, stop, bus_timeout};
    if (scl_rise) rise_cnt++;
    if (scl_fall) fall_cnt++;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check_val({exp_q[0].tag, "_missing"}, 32'(4'b0000), 32'(exp_q[0].vec));
      exp_q.delete(0);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      ent = exp_q.pop_front();
      $display("txn %s cyc=%0d vec=%b", ent.tag, cyc, mon_vec);
      check_val(ent.tag, 32'(mon_vec), 32'(ent.vec));
    end else if (mon_vec != 4'b0000) begin
      check_val("unexpected_pulse", 32'(mon_vec), 32'(4'b0000));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with pins low: lines must still read idle-high.
    rst_n = 1'b0;
    pins(1'b0, 1'b0);
    step(3);
    check_val("rst_scl_f", 32'(scl_f), 32'(1));
    check_val("rst_sda_f", 32'(sda_f), 32'(1));
    check_val("rst_busy", 32'(bus_busy), 32'(0));
    check_val("rst_timeout", 32'(bus_timeout), 32'(0));
    pins(1'b1, 1'b1);
    step(1);
    rst_n = 1'b1;
    step(12);
    check_val("idle_scl_f", 32'(scl_f), 32'(1));
    check_val("idle_sda_f", 32'(sda_f), 32'(1));
    check_val("idle_busy", 32'(bus_busy), 32'(0));

    // START from idle
    pins(1'b1, 1'b0);
    c0 = cyc;
    push_exp("start", c0 + LAT, V_START);
    step(LAT);
    check_val("busy_at_start", 32'(bus_busy), 32'(0));
    step(1);
    check_val("busy_after_start", 32'(bus_busy), 32'(1));
    step(8);

    // Nine SCL clocks, data set high during the last low phase
    r0 = rise_cnt;
    f0 = fall_cnt;
    for (int i = 0; i < 9; i++) begin
      pins(1'b0, sda_in);
      step(8);
      if (i == 8) begin
        pins(1'b0, 1'b1);
        step(8);
      end
      pins(1'b1, sda_in);
      step(8);
    end
    check_val("scl_rise_count", 32'(rise_cnt - r0), 32'(9));
    check_val("scl_fall_count", 32'(fall_cnt - f0), 32'(9));

    // Repeated START while busy
    pins(1'b1, 1'b0);
    c0 = cyc;
    push_exp("rstart", c0 + LAT, V_RSTART);
    step(LAT);
    check_val("busy_at_rstart", 32'(bus_busy), 32'(1));
    step(1);
    check_val("busy_after_rstart", 32'(bus_busy), 32'(1));
    step(8);

    // STOP
    pins(1'b1, 1'b1);
    c0 = cyc;
    push_exp("stop", c0 + LAT, V_STOP);
    step(LAT);
    check_val("busy_at_stop", 32'(bus_busy), 32'(1));
    step(1);
    check_val("busy_after_stop", 32'(bus_busy), 32'(0));
    step(8);

    // Two-cycle SDA glitch is rejected
    pins(1'b1, 1'b0);
    step(2);
    pins(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_val("glitch_sda_f", 32'(sda_f), 32'(1));
    end

    // Three-cycle SDA low: START, then STOP once the line returns
    pins(1'b1, 1'b0);
    c0 = cyc;
    push_exp("start_3cyc", c0 + LAT, V_START);
    push_exp("stop_3cyc", c0 + LAT + 3, V_STOP);
    step(3);
    pins(1'b1, 1'b1);
    step(LAT - 2);
    check_val("busy_3cyc", 32'(bus_busy), 32'(1));
    step(3);
    check_val("busy_3cyc_end", 32'(bus_busy), 32'(0));
    step(10);

    // STOP while idle still pulses stop, busy stays low
    pins(1'b0, 1'b1);
    step(8);
    pins(1'b0, 1'b0);
    step(8);
    pins(1'b1, 1'b0);
    step(8);
    pins(1'b1, 1'b1);
    c0 = cyc;
    push_exp("stop_idle", c0 + LAT, V_STOP);
    step(LAT + 1);
    check_val("busy_stop_idle", 32'(bus_busy), 32'(0));
    step(8);

    // Both lines move together: no condition either way
    pins(1'b0, 1'b0);
    step(10);
    check_val("both_low_scl_f", 32'(scl_f), 32'(0));
    check_val("both_low_sda_f", 32'(sda_f), 32'(0));
    pins(1'b1, 1'b1);
    step(10);
    check_val("both_high_busy", 32'(bus_busy), 32'(0));

    // Reset in the middle of a transfer, released with pins low
    pins(1'b1, 1'b0);
    c0 = cyc;
    push_exp("start_pre_rst", c0 + LAT, V_START);
    step(LAT + 2);
    check_val("busy_pre_rst", 32'(bus_busy), 32'(1));
    pins(1'b0, 1'b0);
    step(8);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(bus_busy), 32'(0));
    check_val("mid_rst_scl_f", 32'(scl_f), 32'(1));
    check_val("mid_rst_sda_f", 32'(sda_f), 32'(1));
    step(3);
    rst_n = 1'b1;
    step(12);
    check_val("post_rst_busy", 32'(bus_busy), 32'(0));
    check_val("post_rst_scl_f", 32'(scl_f), 32'(0));
    pins(1'b1, 1'b1);
    step(12);
    check_val("post_rst_idle_busy", 32'(bus_busy), 32'(0));

    // SCL held low while busy
    pins(1'b1, 1'b0);
    c0 = cyc;
    push_exp("start_pre_to", c0 + LAT, V_START);
    step(LAT + 2);
    check_val("busy_pre_to", 32'(bus_busy), 32'(1));
    pins(1'b0, 1'b0);
    c1 = cyc;
`ifdef I2C_BUS_TIMEOUT_EN
    push_exp("timeout", c1 + SYNC + FILT + TO, V_TO);
    step(SYNC + FILT + TO);
    check_val("busy_at_timeout", 32'(bus_busy), 32'(1));
    step(1);
    check_val("busy_after_timeout", 32'(bus_busy), 32'(0));
    step(5);
    pins(1'b1, 1'b1);
    step(12);
    check_val("busy_post_timeout", 32'(bus_busy), 32'(0));
`else
    step(40);
    check_val("no_timeout", 32'(bus_timeout), 32'(0));
    check_val("busy_held_low", 32'(bus_busy), 32'(1));
    pins(1'b1, 1'b0);
    step(8);
    pins(1'b1, 1'b1);
    c0 = cyc;
    push_exp("stop_after_hold", c0 + LAT, V_STOP);
    step(LAT + 1);
    check_val("busy_after_hold_stop", 32'(bus_busy), 32'(0));
`endif

    step(20);
    check_val("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
